// File: rtl/byte_feed_fifo.sv
// byte_feed_fifo: first-word-fall-through byte FIFO feeding the serial/port
// consumer stage. Valid/ready on both sides, registered head byte, fill level
// and synchronous flush.
//
// Optional feature macro: BYTE_FEED_FIFO_PARITY_EN
//   When defined, each entry also stores the even parity (XOR reduction) of its
//   byte. The stored bit is presented on out_parity. A sticky parity_err flags
//   any checked push (in_parity_chk=1) whose in_parity bit disagrees with the
//   computed parity.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready.
// in_ready is !full, decoded only from the registered level, so it does not
// depend on out_ready. The producer holds in_data while in_valid && !in_ready.
// The FIFO holds out_data while out_valid && !out_ready.
module byte_feed_fifo #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
`ifdef BYTE_FEED_FIFO_PARITY_EN
    output logic                       out_parity,
    input  logic                       in_parity_chk,
    input  logic                       in_parity,
    output logic                       parity_err,
`endif
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);
`ifdef BYTE_FEED_FIFO_PARITY_EN
    localparam int EW = DATA_W + 1;
`else
    localparam int EW = DATA_W;
`endif

    logic [EW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [LW-1:0] level_q;
    logic [EW-1:0] head_q;
    logic [EW-1:0] head_d;
    logic [EW-1:0] entry_in;
    logic          push;
    logic          pop;

    // The entry written at push time; parity travels with the byte.
`ifdef BYTE_FEED_FIFO_PARITY_EN
    assign entry_in = {^in_data, in_data};
`else
    assign entry_in = in_data;
`endif

    assign in_ready  = (level_q != LW'(DEPTH));
    assign out_valid = (level_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign level     = level_q;
    assign out_data  = head_q[DATA_W-1:0];
`ifdef BYTE_FEED_FIFO_PARITY_EN
    assign out_parity = head_q[DATA_W];
`endif

    // Storage array: written on an accepted push, never reset.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= entry_in;
        end
    end

    // Next head register: after a pop it is the following stored entry, or the
    // byte being pushed in the same cycle when that is the only one left.
    // Pushing into an empty FIFO loads the head directly (latency 1). When the
    // FIFO drains, the head keeps its last value.
    always_comb begin
        head_d = head_q;
        if (!flush) begin
            if (pop) begin
                if (level_q >= LW'(2)) begin
                    head_d = mem[rd_ptr + PW'(1)];
                end else if (push) begin
                    head_d = entry_in;
                end
            end else if (push && (level_q == '0)) begin
                head_d = entry_in;
            end
        end
    end

    // Pointers, level and head register; flush overrides push and pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            head_q  <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            head_q <= head_d;
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

`ifdef BYTE_FEED_FIFO_PARITY_EN
    // Sticky parity error, cleared only by reset or flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parity_err <= 1'b0;
        end else if (flush) begin
            parity_err <= 1'b0;
        end else if (push && in_parity_chk && (in_parity != ^in_data)) begin
            parity_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_byte_feed_fifo.sv
// tb_byte_feed_fifo: directed bench for byte_feed_fifo (DEPTH=8) with a queue
// scoreboard. Accepted bytes are queued when driven and compared when popped.
module tb_byte_feed_fifo;

    localparam int DEPTH  = 8;
    localparam int DATA_W = 8;
    localparam int LW     = $clog2(DEPTH+1);

    logic              clk;
    logic              rst;
    logic              flush;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic [LW-1:0]     level;
`ifdef BYTE_FEED_FIFO_PARITY_EN
    logic              out_parity;
    logic              in_parity_chk;
    logic              in_parity;
    logic              parity_err;
`endif

    int test_cnt = 0;
    int fail_cnt = 0;
    logic [DATA_W-1:0] exp_q[$];

    byte_feed_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
`ifdef BYTE_FEED_FIFO_PARITY_EN
        .out_parity    (out_parity),
        .in_parity_chk (in_parity_chk),
        .in_parity     (in_parity),
        .parity_err    (parity_err),
`endif
        .level         (level)
    );

    // Clock: 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        test_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus: drive on the falling edge, check the registered
    // outputs against the scoreboard, then update the model for the coming edge.
    task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic r,
                        input logic f, input string tag);
        int n;
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        #1;
        n = exp_q.size();
        check({tag, ":level"},     32'(level),     32'(n));
        check({tag, ":out_valid"}, 32'(out_valid), 32'(n != 0));
        check({tag, ":in_ready"},  32'(in_ready),  32'(n != DEPTH));
        if (n != 0 && !r) begin
            check({tag, ":hold_data"}, 32'(out_data), 32'(exp_q[0]));
        end
        if (f) begin
            exp_q.delete();
        end else begin
            if (r && n != 0) begin
                check({tag, ":pop_data"}, 32'(out_data), 32'(exp_q.pop_front()));
            end
            if (v && n != DEPTH) begin
                exp_q.push_back(d);
            end
        end
    endtask

    initial begin
        logic [DATA_W-1:0] d;
        rst       = 1'b0;
        flush     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
`ifdef BYTE_FEED_FIFO_PARITY_EN
        in_parity_chk = 1'b0;
        in_parity     = 1'b0;
`endif

        // Reset values while rst is low.
        repeat (2) @(negedge clk);
        check("rst:level",     32'(level),     32'd0);
        check("rst:out_valid", 32'(out_valid), 32'd0);
        check("rst:in_ready",  32'(in_ready),  32'd1);
        check("rst:out_data",  32'(out_data),  32'd0);
        rst = 1'b1;

        // Idle for 10 cycles after release.
        for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b0, 1'b0, "idle");

        // Single byte.
        step(1'b1, 8'hA5, 1'b0, 1'b0, "single_push");
        step(1'b0, 8'h00, 1'b0, 1'b0, "single_hold");
        step(1'b0, 8'h00, 1'b1, 1'b0, "single_pop");
        step(1'b0, 8'h00, 1'b0, 1'b0, "single_empty");

        // Fill to full, hold 0x08 under back-pressure, pop once, then drain.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0, "fill");
        step(1'b1, 8'h08, 1'b0, 1'b0, "full_blocked");
        step(1'b1, 8'h08, 1'b0, 1'b0, "full_blocked");
        step(1'b1, 8'h08, 1'b1, 1'b0, "full_pop");
        step(1'b1, 8'h08, 1'b0, 1'b0, "retry_push");
        for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, 1'b0, "drain");
        step(1'b0, 8'h00, 1'b0, 1'b0, "drained");

        // Wrap and concurrency at level 3.
        d = 8'($urandom_range(0, 200));
        for (int i = 0; i < 3; i++) begin
            step(1'b1, d, 1'b0, 1'b0, "wrap_fill");
            d = d + 8'd1;
        end
        for (int i = 0; i < 20; i++) begin
            step(1'b1, d, 1'b1, 1'b0, "wrap_conc");
            d = d + 8'd1;
        end
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0, "wrap_drain");

        // Flush mid-burst at level 5, with a push and pop in the same cycle.
        for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0, "flush_fill");
        step(1'b1, 8'h77, 1'b1, 1'b1, "flush");
        step(1'b1, 8'h3C, 1'b0, 1'b0, "post_flush_push");
        step(1'b0, 8'h00, 1'b1, 1'b0, "post_flush_pop");
        step(1'b0, 8'h00, 1'b0, 1'b0, "post_flush_empty");

        // Asynchronous reset mid-burst at level 4.
        for (int i = 0; i < 4; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0, "areset_fill");
        @(posedge clk);
        #1;
        check("areset:level_before", 32'(level), 32'd4);
        in_valid = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        check("areset:level",     32'(level),     32'd0);
        check("areset:out_valid", 32'(out_valid), 32'd0);
        check("areset:in_ready",  32'(in_ready),  32'd1);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        step(1'b1, 8'h11, 1'b0, 1'b0, "areset_push");
        step(1'b0, 8'h00, 1'b1, 1'b0, "areset_pop");
        step(1'b0, 8'h00, 1'b0, 1'b0, "areset_empty");

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule
